// File: rtl/ex_mem_reg_pkg.sv
// Shared CPU pipeline definitions: datapath widths and the control/stage bundles
// carried through the EX/MEM register.
package ex_mem_reg_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
    logic jump;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

  typedef struct packed {
    logic                  valid;
    ctrl_t                 ctrl;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     branch_target;
    logic [REG_ADDR_W-1:0] write_reg;
  } stage_t;

  // A bubble clears the data fields as well as the control bundle.
  localparam stage_t BUBBLE = '0;

endpackage

// File: rtl/ex_mem_reg_sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = 1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures ALU output and EX control, resolves
// conditional branches from the registered flag and squashes the wrong path.
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic [DATA_W-1:0]     alu_result_i,
  input  logic                  alu_jump_i,
  input  logic                  branch_i,
  input  logic [DATA_W-1:0]     branch_target_i,
  input  logic [DATA_W-1:0]     rt_data_i,
  input  logic [REG_ADDR_W-1:0] write_reg_i,
  input  logic                  reg_write_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic                  mem_to_reg_i,
  output logic                  valid_o,
  output logic [DATA_W-1:0]     alu_result_o,
  output logic [DATA_W-1:0]     rt_data_o,
  output logic [REG_ADDR_W-1:0] write_reg_o,
  output logic                  reg_write_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic                  mem_to_reg_o,
  output logic [DATA_W-1:0]     branch_target_o,
  output logic                  pc_src_o,
  output logic                  flush_front_o,
  output logic [CNT_W-1:0]      retired_cnt_o,
  output logic [CNT_W-1:0]      squash_cnt_o
);

  stage_t q;
  stage_t in_stage;
  logic   taken_q;
  logic   retired_inc;
  logic   squash_inc;

  // An invalid EX slot is loaded as a full bubble so no stale field leaks downstream.
  always_comb begin
    in_stage = BUBBLE;
    if (valid_i) begin
      in_stage.valid           = 1'b1;
      in_stage.ctrl.reg_write  = reg_write_i;
      in_stage.ctrl.mem_read   = mem_read_i;
      in_stage.ctrl.mem_write  = mem_write_i;
      in_stage.ctrl.mem_to_reg = mem_to_reg_i;
      in_stage.ctrl.branch     = branch_i;
      in_stage.ctrl.jump       = alu_jump_i;
      in_stage.alu_result      = alu_result_i;
      in_stage.rt_data         = rt_data_i;
      in_stage.branch_target   = branch_target_i;
      in_stage.write_reg       = write_reg_i;
    end
  end

  assign taken_q = q.valid & q.ctrl.branch & q.ctrl.jump;

  // Load priority: flush, then stall (hold), then wrong-path squash, then capture.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      q <= BUBBLE;
    end else if (flush_i) begin
      q <= BUBBLE;
    end else if (stall_i) begin
      q <= q;
    end else if (taken_q) begin
      q <= BUBBLE;
    end else begin
      q <= in_stage;
    end
  end

  // Redirect is suppressed while stalled, so a held taken branch redirects once.
  assign pc_src_o      = taken_q & ~stall_i;
  assign flush_front_o = taken_q & ~stall_i;

  assign valid_o         = q.valid;
  assign alu_result_o    = q.alu_result;
  assign rt_data_o       = q.rt_data;
  assign write_reg_o     = q.write_reg;
  assign reg_write_o     = q.ctrl.reg_write;
  assign mem_read_o      = q.ctrl.mem_read;
  assign mem_write_o     = q.ctrl.mem_write;
  assign mem_to_reg_o    = q.ctrl.mem_to_reg;
  assign branch_target_o = q.branch_target;

  assign retired_inc = q.valid & ~stall_i & ~flush_i;
  assign squash_inc  = ~flush_i & ~stall_i & taken_q & valid_i;

  sat_counter #(.W(CNT_W)) u_retired_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (retired_inc),
    .count (retired_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_squash_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (squash_inc),
    .count (squash_cnt_o)
  );

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: vector table for plain loads, hand sequences
// for branch redirect, stall, flush, saturation and asynchronous reset.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, valid, alu_jump, branch;
  logic [31:0] alu_result, branch_target, rt_data;
  logic [4:0]  write_reg;
  logic        reg_write, mem_read, mem_write, mem_to_reg;

  logic        valid_q, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
  logic [31:0] alu_result_q, rt_data_q, branch_target_q;
  logic [4:0]  write_reg_q;
  logic        pc_src, flush_front;
  logic [15:0] retired_cnt, squash_cnt;

  logic        s_valid, s_rw, s_mr, s_mw, s_m2r, s_pc, s_ff;
  logic [31:0] s_alu, s_rt, s_tgt;
  logic [4:0]  s_wr;
  logic [3:0]  s_ret, s_sq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_reg u_dut (
    .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .flush_i(flush), .valid_i(valid),
    .alu_result_i(alu_result), .alu_jump_i(alu_jump), .branch_i(branch),
    .branch_target_i(branch_target), .rt_data_i(rt_data), .write_reg_i(write_reg),
    .reg_write_i(reg_write), .mem_read_i(mem_read), .mem_write_i(mem_write),
    .mem_to_reg_i(mem_to_reg), .valid_o(valid_q), .alu_result_o(alu_result_q),
    .rt_data_o(rt_data_q), .write_reg_o(write_reg_q), .reg_write_o(reg_write_q),
    .mem_read_o(mem_read_q), .mem_write_o(mem_write_q), .mem_to_reg_o(mem_to_reg_q),
    .branch_target_o(branch_target_q), .pc_src_o(pc_src), .flush_front_o(flush_front),
    .retired_cnt_o(retired_cnt), .squash_cnt_o(squash_cnt)
  );

  ex_mem_reg #(.CNT_W(4)) u_small (
    .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .flush_i(flush), .valid_i(valid),
    .alu_result_i(alu_result), .alu_jump_i(alu_jump), .branch_i(branch),
    .branch_target_i(branch_target), .rt_data_i(rt_data), .write_reg_i(write_reg),
    .reg_write_i(reg_write), .mem_read_i(mem_read), .mem_write_i(mem_write),
    .mem_to_reg_i(mem_to_reg), .valid_o(s_valid), .alu_result_o(s_alu),
    .rt_data_o(s_rt), .write_reg_o(s_wr), .reg_write_o(s_rw),
    .mem_read_o(s_mr), .mem_write_o(s_mw), .mem_to_reg_o(s_m2r),
    .branch_target_o(s_tgt), .pc_src_o(s_pc), .flush_front_o(s_ff),
    .retired_cnt_o(s_ret), .squash_cnt_o(s_sq)
  );

  typedef struct {
    logic        valid, stall, flush, rw, mw;
    logic [31:0] alu, rt;
    logic [4:0]  wr;
    logic        e_valid, e_rw, e_mw;
    logic [31:0] e_alu, e_rt;
    logic [4:0]  e_wr;
    logic [15:0] e_ret;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    stall = 0; flush = 0; valid = 0; alu_jump = 0; branch = 0;
    alu_result = '0; branch_target = '0; rt_data = '0; write_reg = '0;
    reg_write = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    #3 rst_n = 0;
    #4 rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic take_branch(input logic [31:0] tgt);
    idle();
    valid = 1; branch = 1; alu_jump = 1; branch_target = tgt;
  endtask

  initial begin
    int pulses;
    rst_n = 0;
    idle();
    #2;
    chk("reset_valid", {31'b0, valid_q}, 32'h0);
    chk("reset_pc_src", {31'b0, pc_src}, 32'h0);
    chk("reset_retired", {16'b0, retired_cnt}, 32'h0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    vecs[0] = '{1,0,0,1,0, 32'h10,       32'h0,    5'd5,  1,1,0, 32'h10,       32'h0,    5'd5,  16'd0};
    vecs[1] = '{1,0,0,0,1, 32'hdeadbeef, 32'h1234, 5'd31, 1,0,1, 32'hdeadbeef, 32'h1234, 5'd31, 16'd1};
    vecs[2] = '{1,1,0,1,0, 32'h55,       32'h0,    5'd3,  1,0,1, 32'hdeadbeef, 32'h1234, 5'd31, 16'd1};
    vecs[3] = '{0,0,0,1,1, 32'h77,       32'h88,   5'd7,  0,0,0, 32'h0,        32'h0,    5'd0,  16'd2};
    vecs[4] = '{1,1,1,0,1, 32'h99,       32'haa,   5'd9,  0,0,0, 32'h0,        32'h0,    5'd0,  16'd2};
    vecs[5] = '{1,0,0,1,0, 32'hffffffff, 32'hcafe, 5'd1,  1,1,0, 32'hffffffff, 32'hcafe, 5'd1,  16'd2};
    vecs[6] = '{1,0,1,1,1, 32'h1234,     32'h5678, 5'd4,  0,0,0, 32'h0,        32'h0,    5'd0,  16'd2};
    vecs[7] = '{1,0,0,0,0, 32'habc,      32'h0,    5'd0,  1,0,0, 32'habc,      32'h0,    5'd0,  16'd2};

    foreach (vecs[i]) begin
      idle();
      valid = vecs[i].valid; stall = vecs[i].stall; flush = vecs[i].flush;
      reg_write = vecs[i].rw; mem_write = vecs[i].mw; alu_result = vecs[i].alu;
      rt_data = vecs[i].rt; write_reg = vecs[i].wr;
      tick();
      chk($sformatf("vec%0d_valid", i), {31'b0, valid_q}, {31'b0, vecs[i].e_valid});
      chk($sformatf("vec%0d_alu", i), alu_result_q, vecs[i].e_alu);
      chk($sformatf("vec%0d_rt", i), rt_data_q, vecs[i].e_rt);
      chk($sformatf("vec%0d_wr", i), {27'b0, write_reg_q}, {27'b0, vecs[i].e_wr});
      chk($sformatf("vec%0d_rw", i), {31'b0, reg_write_q}, {31'b0, vecs[i].e_rw});
      chk($sformatf("vec%0d_mw", i), {31'b0, mem_write_q}, {31'b0, vecs[i].e_mw});
      chk($sformatf("vec%0d_retired", i), {16'b0, retired_cnt}, {16'b0, vecs[i].e_ret});
      chk($sformatf("vec%0d_squash", i), {16'b0, squash_cnt}, 32'h0);
      chk($sformatf("vec%0d_pc_src", i), {31'b0, pc_src}, 32'h0);
    end

    // Taken branch followed by a wrong-path ALU op.
    do_reset();
    take_branch(32'h40);
    tick();
    idle();
    valid = 1; alu_result = 32'h20; write_reg = 5'd2; reg_write = 1;
    #1;
    chk("br_pc_src", {31'b0, pc_src}, 32'h1);
    chk("br_flush_front", {31'b0, flush_front}, 32'h1);
    chk("br_target", branch_target_q, 32'h40);
    tick();
    chk("br_squash_valid", {31'b0, valid_q}, 32'h0);
    chk("br_squash_rw", {31'b0, reg_write_q}, 32'h0);
    chk("br_pc_src_off", {31'b0, pc_src}, 32'h0);
    chk("br_squash_cnt", {16'b0, squash_cnt}, 32'h1);
    chk("br_retired", {16'b0, retired_cnt}, 32'h1);

    // Taken branch held by a 3-cycle stall redirects exactly once.
    do_reset();
    take_branch(32'h80);
    alu_result = 32'h5;
    tick();
    pulses = 0;
    idle();
    valid = 1; alu_result = 32'h66; stall = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (pc_src) pulses++;
      chk("stall_pc_src", {31'b0, pc_src}, 32'h0);
      tick();
      chk("stall_hold_valid", {31'b0, valid_q}, 32'h1);
      chk("stall_hold_tgt", branch_target_q, 32'h80);
      chk("stall_hold_alu", alu_result_q, 32'h5);
    end
    stall = 0;
    #1;
    if (pc_src) pulses++;
    chk("stall_release_pc_src", {31'b0, pc_src}, 32'h1);
    tick();
    if (pc_src) pulses++;
    chk("stall_pulses", pulses, 32'h1);
    chk("stall_squash_valid", {31'b0, valid_q}, 32'h0);
    chk("stall_squash_cnt", {16'b0, squash_cnt}, 32'h1);
    chk("stall_retired", {16'b0, retired_cnt}, 32'h1);

    // Flush on the same cycle as a resolved branch: bubble, redirect, no squash count.
    do_reset();
    take_branch(32'h100);
    tick();
    idle();
    valid = 1; flush = 1; mem_write = 1;
    #1;
    chk("flush_br_pc_src", {31'b0, pc_src}, 32'h1);
    tick();
    chk("flush_br_valid", {31'b0, valid_q}, 32'h0);
    chk("flush_br_squash_cnt", {16'b0, squash_cnt}, 32'h0);
    chk("flush_br_retired", {16'b0, retired_cnt}, 32'h0);

    // Back-to-back taken branches: the second is squashed, never redirects.
    do_reset();
    take_branch(32'h100);
    tick();
    take_branch(32'h200);
    #1;
    chk("b2b_first_pc_src", {31'b0, pc_src}, 32'h1);
    chk("b2b_first_tgt", branch_target_q, 32'h100);
    tick();
    idle();
    chk("b2b_second_valid", {31'b0, valid_q}, 32'h0);
    chk("b2b_second_pc_src", {31'b0, pc_src}, 32'h0);
    tick();
    chk("b2b_no_redirect", {31'b0, pc_src}, 32'h0);
    chk("b2b_squash_cnt", {16'b0, squash_cnt}, 32'h1);

    // Saturation: 20 valid instructions retire; the 4-bit counter sticks at 15.
    do_reset();
    for (int n = 0; n < 20; n++) begin
      idle();
      valid = 1; alu_result = n;
      tick();
    end
    idle();
    tick();
    chk("sat_small_retired", {28'b0, s_ret}, 32'd15);
    chk("sat_wide_retired", {16'b0, retired_cnt}, 32'd20);

    // Asynchronous reset between edges while a taken branch is redirecting.
    take_branch(32'h300);
    tick();
    idle();
    #1;
    chk("arst_pre_pc_src", {31'b0, pc_src}, 32'h1);
    #1 rst_n = 0;
    #1;
    chk("arst_pc_src", {31'b0, pc_src}, 32'h0);
    chk("arst_flush_front", {31'b0, flush_front}, 32'h0);
    chk("arst_valid", {31'b0, valid_q}, 32'h0);
    chk("arst_tgt", branch_target_q, 32'h0);
    chk("arst_retired", {16'b0, retired_cnt}, 32'h0);
    chk("arst_small_retired", {28'b0, s_ret}, 32'h0);
    chk("arst_squash", {16'b0, squash_cnt}, 32'h0);
    #1 rst_n = 1;
    valid = 1; alu_result = 32'h77; write_reg = 5'd9;
    tick();
    chk("arst_first_load_alu", alu_result_q, 32'h77);
    chk("arst_first_load_wr", {27'b0, write_reg_q}, 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
